// File: rtl/inv_add_round_key_if.sv
// inv_add_round_key_if: state-word input and round-result output handshake bundle.
interface inv_add_round_key_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_mix;
    logic         out_last;
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_round, out_mix, out_last
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_round, out_mix, out_last
    );
endinterface

// File: rtl/inv_add_round_key.sv
// inv_add_round_key: AES inverse AddRoundKey stage with round-key store and round sequencing.
module inv_add_round_key #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_we,
    input  logic [3:0]   key_idx,
    input  logic [127:0] key_data,
    input  logic         flush,
    output logic         busy,
    inv_add_round_key_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] key_q [NR+1];
    logic [127:0] key_d [NR+1];
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [3:0]   out_round_q, out_round_d;
    logic         out_mix_q, out_mix_d;
    logic         out_last_q, out_last_d;
    logic         accept;
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready && !flush;
    assign busy          = state_q == RUN;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_round = out_round_q;
    assign bus.out_mix   = out_mix_q;
    assign bus.out_last  = out_last_q;
    // Key reads use key_q, so a same-cycle write is only seen by the next accept.
    always_comb begin
        key_d       = key_q;
        state_d     = state_q;
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_round_d = out_round_q;
        out_mix_d   = out_mix_q;
        out_last_d  = out_last_q;
        if (key_we && key_idx <= 4'(NR))
            key_d[key_idx] = key_data;
        if (flush) begin
            state_d     = IDLE;
            rnd_d       = 4'(NR);
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data ^ key_q[rnd_q];
            out_round_d = rnd_q;
            out_last_d  = rnd_q == 4'd0;
            out_mix_d   = rnd_q != 4'(NR) && rnd_q != 4'd0;
            state_d     = (state_q == IDLE || rnd_q != 4'd0) ? RUN : IDLE;
            rnd_d       = state_q == IDLE ? 4'(NR - 1) : (rnd_q == 4'd0 ? 4'(NR) : rnd_q - 4'd1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q       <= '{default: '0};
            state_q     <= IDLE;
            rnd_q       <= 4'(NR);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            out_mix_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            key_q       <= key_d;
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_round_q <= out_round_d;
            out_mix_q   <= out_mix_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule
